decode_buffer: RTL and testbench

//  Parametrised successor to the single-cycle decoder. Sits between fetch and dispatcher.

---
 rtl/decoder_pkg.sv | 44 ++++
 rtl/decode_buffer_if.sv | 33 +++
 rtl/inst_decode_comb.sv | 114 +++++++++++
 rtl/decode_buffer.sv | 128 ++++++++++++
 tb/tb_decode_buffer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared RV32I decode definitions: opcode classes, function codes, micro-op codes and
// the immediate-format helper used by the decode buffer.
package decoder_pkg;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcRi     = 7'b0010011;
  localparam logic [6:0] OpcRr     = 7'b0110011;

  localparam logic [6:0] ClassNop = 7'b0000000;
  localparam logic [6:0] F7Zero   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam int unsigned NameFree = 0;

  typedef enum logic [5:0] {
    OpNop, OpLui, OpAuipc, OpJal, OpJalr,
    OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu,
    OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw,
    OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi, OpSlli, OpSrli, OpSrai,
    OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd
  } op_bus_e;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ, ImmZ} imm_fmt_e;

  // 32-bit sign-extended immediate for the given instruction format.
  function automatic logic [31:0] imm32(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      ImmI:    imm = {{20{inst[31]}}, inst[31:20]};
      ImmS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      ImmB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      ImmU:    imm = {inst[31:12], 12'h000};
      ImmJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_buffer_if.sv
// Fetch-side and dispatch-side handshake bundle of the decode buffer.
interface decode_buffer_if #(
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32,
  parameter int unsigned NameW = 5
);
  import decoder_pkg::*;

  logic             fetch_valid;
  logic             fetch_ready;
  logic [AddrW-1:0] fetch_pc;
  logic [31:0]      fetch_inst;
  logic             dec_valid;
  logic             dec_ready;
  logic [NameW-1:0] rs1;
  logic [NameW-1:0] rs2;
  logic [NameW-1:0] rd;
  op_bus_e          op_code;
  logic [6:0]       op_class;
  logic [AddrW-1:0] inst_addr;
  logic [DataW-1:0] imm;
  logic             illegal;

  modport master (
    output fetch_valid, fetch_pc, fetch_inst, dec_ready,
    input  fetch_ready, dec_valid, rs1, rs2, rd, op_code, op_class, inst_addr, imm, illegal
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_inst, dec_ready,
    output fetch_ready, dec_valid, rs1, rs2, rd, op_code, op_class, inst_addr, imm, illegal
  );
endinterface

// File: rtl/inst_decode_comb.sv
// Purely combinational RV32I decoder: raw instruction to masked micro-op fields.
module inst_decode_comb import decoder_pkg::*; #(
  parameter int unsigned DataW = 32,
  parameter int unsigned NameW = 5
) (
  input  logic [31:0]      inst_i,
  output op_bus_e          op_code_o,
  output logic [6:0]       op_class_o,
  output logic [NameW-1:0] rs1_o,
  output logic [NameW-1:0] rs2_o,
  output logic [NameW-1:0] rd_o,
  output logic [DataW-1:0] imm_o,
  output logic             illegal_o
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  op_bus_e    op;
  imm_fmt_e   fmt;
  logic       use_rs1, use_rs2, use_rd;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];

  // Every legal encoding maps to a non-NOP op, so OpNop doubles as the illegal marker.
  always_comb begin
    op      = OpNop;
    fmt     = ImmZ;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    use_rd  = 1'b1;
    case (opc)
      OpcLui:   begin op = OpLui;   fmt = ImmU; use_rs1 = 1'b0; end
      OpcAuipc: begin op = OpAuipc; fmt = ImmU; use_rs1 = 1'b0; end
      OpcJal:   begin op = OpJal;   fmt = ImmJ; use_rs1 = 1'b0; end
      OpcJalr: begin
        fmt = ImmI;
        if (f3 == 3'b000) op = OpJalr;
      end
      OpcBranch: begin
        fmt = ImmB; use_rs2 = 1'b1; use_rd = 1'b0;
        case (f3)
          3'b000: op = OpBeq;
          3'b001: op = OpBne;
          3'b100: op = OpBlt;
          3'b101: op = OpBge;
          3'b110: op = OpBltu;
          3'b111: op = OpBgeu;
          default: op = OpNop;
        endcase
      end
      OpcLoad: begin
        fmt = ImmI;
        case (f3)
          3'b000: op = OpLb;
          3'b001: op = OpLh;
          3'b010: op = OpLw;
          3'b100: op = OpLbu;
          3'b101: op = OpLhu;
          default: op = OpNop;
        endcase
      end
      OpcStore: begin
        fmt = ImmS; use_rs2 = 1'b1; use_rd = 1'b0;
        case (f3)
          3'b000: op = OpSb;
          3'b001: op = OpSh;
          3'b010: op = OpSw;
          default: op = OpNop;
        endcase
      end
      OpcRi: begin
        fmt = ImmI;
        case (f3)
          3'b000: op = OpAddi;
          3'b010: op = OpSlti;
          3'b011: op = OpSltiu;
          3'b100: op = OpXori;
          3'b110: op = OpOri;
          3'b111: op = OpAndi;
          3'b001: op = (f7 == F7Zero) ? OpSlli : OpNop;
          default: op = (f7 == F7Zero) ? OpSrli : (f7 == F7Alt) ? OpSrai : OpNop;
        endcase
      end
      OpcRr: begin
        use_rs2 = 1'b1;
        case ({f7, f3})
          {F7Zero, 3'b000}: op = OpAdd;
          {F7Alt,  3'b000}: op = OpSub;
          {F7Zero, 3'b001}: op = OpSll;
          {F7Zero, 3'b010}: op = OpSlt;
          {F7Zero, 3'b011}: op = OpSltu;
          {F7Zero, 3'b100}: op = OpXor;
          {F7Zero, 3'b101}: op = OpSrl;
          {F7Alt,  3'b101}: op = OpSra;
          {F7Zero, 3'b110}: op = OpOr;
          {F7Zero, 3'b111}: op = OpAnd;
          default: op = OpNop;
        endcase
      end
      default: op = OpNop;
    endcase
  end

  // An illegal word becomes a bare NOP: no names, no immediate.
  assign illegal_o  = (op == OpNop);
  assign op_code_o  = op;
  assign op_class_o = illegal_o ? ClassNop : opc;
  assign rs1_o = (illegal_o || !use_rs1) ? NameW'(NameFree) : NameW'(inst_i[19:15]);
  assign rs2_o = (illegal_o || !use_rs2) ? NameW'(NameFree) : NameW'(inst_i[24:20]);
  assign rd_o  = (illegal_o || !use_rd)  ? NameW'(NameFree) : NameW'(inst_i[11:7]);
  assign imm_o = illegal_o ? '0 : DataW'($signed(imm32(inst_i, fmt)));

endmodule

// File: rtl/decode_buffer.sv
// Fetch-to-dispatch decode buffer: DEPTH-entry {pc, inst} FIFO with empty-bypass, feeding a
// registered decoded micro-op held until the dispatcher accepts it.
module decode_buffer import decoder_pkg::*; #(
  parameter int unsigned Depth = 4,
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32,
  parameter int unsigned NameW = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  decode_buffer_if.slave       bus,
  output logic [$clog2(Depth):0] count_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [AddrW-1:0] pc_mem_q   [Depth];
  logic [31:0]      inst_mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             dec_valid_q, dec_valid_d;

  logic             out_free, enq, deq, bypass, push, load;
  logic [AddrW-1:0] sel_pc;
  logic [31:0]      sel_inst;

  op_bus_e          dc_op, op_q;
  logic [6:0]       dc_class, class_q;
  logic [NameW-1:0] dc_rs1, dc_rs2, dc_rd, rs1_q, rs2_q, rd_q;
  logic [DataW-1:0] dc_imm, imm_q;
  logic             dc_illegal, illegal_q;
  logic [AddrW-1:0] addr_q;

  assign bus.fetch_ready = (count_q < CntW'(Depth));
  assign out_free = !dec_valid_q || bus.dec_ready;
  assign enq      = bus.fetch_valid && bus.fetch_ready && !flush_i;
  assign deq      = out_free && (count_q != '0) && !flush_i;
  // The FIFO head always wins; a fetch word skips the FIFO only when it is empty.
  assign bypass   = out_free && (count_q == '0) && enq;
  assign push     = enq && !bypass;
  assign load     = deq || bypass;
  assign sel_pc   = deq ? pc_mem_q[rd_ptr_q]   : bus.fetch_pc;
  assign sel_inst = deq ? inst_mem_q[rd_ptr_q] : bus.fetch_inst;

  inst_decode_comb #(
    .DataW(DataW),
    .NameW(NameW)
  ) u_decode (
    .inst_i    (sel_inst),
    .op_code_o (dc_op),
    .op_class_o(dc_class),
    .rs1_o     (dc_rs1),
    .rs2_o     (dc_rs2),
    .rd_o      (dc_rd),
    .imm_o     (dc_imm),
    .illegal_o (dc_illegal)
  );

  always_comb begin
    count_d     = count_q;
    dec_valid_d = dec_valid_q;
    if (flush_i) begin
      count_d     = '0;
      dec_valid_d = 1'b0;
    end else begin
      count_d = count_q + CntW'(push) - CntW'(deq);
      if (load) dec_valid_d = 1'b1;
      else if (bus.dec_ready) dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= bus.fetch_pc;
      inst_mem_q[wr_ptr_q] <= bus.fetch_inst;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
      op_q        <= OpNop;
      class_q     <= ClassNop;
      rs1_q       <= NameW'(NameFree);
      rs2_q       <= NameW'(NameFree);
      rd_q        <= NameW'(NameFree);
      imm_q       <= '0;
      illegal_q   <= 1'b0;
      addr_q      <= '0;
    end else begin
      count_q     <= count_d;
      dec_valid_q <= dec_valid_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (deq)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (load) begin
        op_q      <= dc_op;
        class_q   <= dc_class;
        rs1_q     <= dc_rs1;
        rs2_q     <= dc_rs2;
        rd_q      <= dc_rd;
        imm_q     <= dc_imm;
        illegal_q <= dc_illegal;
        addr_q    <= sel_pc;
      end
    end
  end

  assign count_o       = count_q;
  assign bus.dec_valid = dec_valid_q;
  assign bus.op_code   = op_q;
  assign bus.op_class  = class_q;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;
  assign bus.rd        = rd_q;
  assign bus.imm       = imm_q;
  assign bus.illegal   = illegal_q;
  assign bus.inst_addr = addr_q;

endmodule

// File: tb/tb_decode_buffer.sv
// Scoreboard bench for decode_buffer: directed scenarios plus randomized traffic checked
// against a table-driven RV32I reference decoder.
module tb_decode_buffer;
  import decoder_pkg::*;

  localparam int unsigned Depth = 4;

  typedef struct packed {
    logic [31:0] pc;
    op_bus_e     op;
    logic [6:0]  cls;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } uop_t;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] count;
  int         n_total = 0;
  int         n_pass = 0;
  uop_t       exp_q[$];

  op_bus_e    br_tab [8] = '{OpBeq, OpBne, OpNop, OpNop, OpBlt, OpBge, OpBltu, OpBgeu};
  op_bus_e    ld_tab [8] = '{OpLb, OpLh, OpLw, OpNop, OpLbu, OpLhu, OpNop, OpNop};
  op_bus_e    st_tab [8] = '{OpSb, OpSh, OpSw, OpNop, OpNop, OpNop, OpNop, OpNop};
  op_bus_e    ri_tab [8] = '{OpAddi, OpSlli, OpSlti, OpSltiu, OpXori, OpSrli, OpOri, OpAndi};
  op_bus_e    rr_tab [8] = '{OpAdd, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpOr, OpAnd};
  logic [6:0] opc_tab [9] = '{OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcBranch, OpcLoad,
                              OpcStore, OpcRi, OpcRr};

  decode_buffer_if #(.AddrW(32), .DataW(32), .NameW(5)) bus ();

  decode_buffer #(.Depth(Depth), .AddrW(32), .DataW(32), .NameW(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .flush_i(flush),
    .bus    (bus),
    .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int sext(input int v, input int bits);
    return (v ^ (1 << (bits - 1))) - (1 << (bits - 1));
  endfunction

  // Reference decode from the instruction-set rules via lookup tables.
  function automatic uop_t model(input logic [31:0] pc, input logic [31:0] w);
    uop_t       u;
    logic [6:0] opc;
    logic [6:0] f7;
    int         f3;
    int         iv;
    opc = w[6:0];
    f7  = w[31:25];
    f3  = int'(w[14:12]);
    iv  = 0;
    u   = '0;
    u.op = OpNop;
    case (opc)
      OpcLui:    begin u.op = OpLui;   iv = int'({w[31:12], 12'h000}); end
      OpcAuipc:  begin u.op = OpAuipc; iv = int'({w[31:12], 12'h000}); end
      OpcJal: begin
        u.op = OpJal;
        iv = sext(int'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
      end
      OpcJalr:   begin u.op = (f3 == 0) ? OpJalr : OpNop; iv = sext(int'(w[31:20]), 12); end
      OpcBranch: begin
        u.op = br_tab[f3];
        iv = sext(int'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
      end
      OpcLoad:   begin u.op = ld_tab[f3]; iv = sext(int'(w[31:20]), 12); end
      OpcStore:  begin u.op = st_tab[f3]; iv = sext(int'({w[31:25], w[11:7]}), 12); end
      OpcRi: begin
        u.op = ri_tab[f3];
        if (f3 == 1 && f7 != 7'h00) u.op = OpNop;
        if (f3 == 5) u.op = (f7 == 7'h00) ? OpSrli : (f7 == 7'h20) ? OpSrai : OpNop;
        iv = sext(int'(w[31:20]), 12);
      end
      OpcRr: begin
        if (f7 == 7'h00) u.op = rr_tab[f3];
        else if (f7 == 7'h20 && f3 == 0) u.op = OpSub;
        else if (f7 == 7'h20 && f3 == 5) u.op = OpSra;
      end
      default: u.op = OpNop;
    endcase
    u.pc = pc;
    if (u.op == OpNop) begin
      u.ill = 1'b1;
    end else begin
      u.cls = opc;
      u.rs1 = (opc inside {OpcLui, OpcAuipc, OpcJal}) ? 5'd0 : w[19:15];
      u.rs2 = (opc inside {OpcBranch, OpcStore, OpcRr}) ? w[24:20] : 5'd0;
      u.rd  = (opc inside {OpcBranch, OpcStore}) ? 5'd0 : w[11:7];
      u.imm = (opc == OpcRr) ? 32'd0 : iv;
    end
    return u;
  endfunction

  function automatic uop_t dut_uop();
    uop_t u;
    u.pc  = bus.inst_addr;
    u.op  = bus.op_code;
    u.cls = bus.op_class;
    u.rs1 = bus.rs1;
    u.rs2 = bus.rs2;
    u.rd  = bus.rd;
    u.imm = bus.imm;
    u.ill = bus.illegal;
    return u;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int          r;
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r < 9) w[6:0] = opc_tab[r];
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // Called at a falling edge: drive one cycle of inputs, log the accepted word, advance.
  task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic dr, input logic fl);
    bus.fetch_valid = fv;
    bus.fetch_pc    = pc;
    bus.fetch_inst  = inst;
    bus.dec_ready   = dr;
    flush           = fl;
    #1;
    if (rst_ni) begin
      if (fl) exp_q.delete();
      else if (fv && bus.fetch_ready) exp_q.push_back(model(pc, inst));
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic dr);
    step(1'b0, 32'h0, 32'h0, dr, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the dispatcher takes a micro-op.
  initial begin
    uop_t exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst_ni) begin
        check("fetch_ready_vs_count", bus.fetch_ready, (count < Depth));
        if (bus.dec_valid && bus.dec_ready && !flush) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL spurious_uop: got uop %0h, expected none", dut_uop());
          end else begin
            exp = exp_q.pop_front();
            check("uop", dut_uop(), exp);
          end
        end
      end
    end
  end

  initial begin
    bus.fetch_valid = 1'b0;
    bus.fetch_pc    = '0;
    bus.fetch_inst  = '0;
    bus.dec_ready   = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    check("rst_dec_valid", bus.dec_valid, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_fetch_ready", bus.fetch_ready, 1'b1);
    check("rst_op_code", bus.op_code, OpNop);
    check("rst_op_class", bus.op_class, ClassNop);
    check("rst_rd", bus.rd, 5'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // Reset in the middle of a stream.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h40 + 32'(4 * i), 32'h00500093, 1'b0, 1'b0);
    check("midrst_pre_count", count, 3'd2);
    #3 rst_ni = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_dec_valid", bus.dec_valid, 1'b0);
    check("midrst_count", count, 3'd0);
    check("midrst_fetch_ready", bus.fetch_ready, 1'b1);
    check("midrst_op_code", bus.op_code, OpNop);
    @(negedge clk);
    rst_ni = 1'b1;
    idle(1'b0);

    // Bypass: one cycle from enqueue to dec_valid.
    step(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b0);
    check("byp_dec_valid", bus.dec_valid, 1'b1);
    check("byp_rd", bus.rd, 5'd1);
    check("byp_rs1", bus.rs1, 5'd0);
    check("byp_rs2", bus.rs2, 5'd0);
    check("byp_imm", bus.imm, 32'd5);
    check("byp_inst_addr", bus.inst_addr, 32'h100);
    check("byp_count", count, 3'd0);

    // Backpressure with the output register occupied: Depth words fit, the next is refused.
    for (int i = 0; i <= Depth; i++)
      step(1'b1, 32'h200 + 32'(4 * i), {12'(i + 1), 5'd0, 3'b000, 5'd2, 7'b0010011}, 1'b0, 1'b0);
    check("full_count", count, 3'(Depth));
    check("full_fetch_ready", bus.fetch_ready, 1'b0);
    check("full_dec_valid_held", bus.inst_addr, 32'h100);
    for (int i = 0; i <= Depth; i++) begin
      check("drain_dec_valid", bus.dec_valid, 1'b1);
      check("drain_count", count, 3'(Depth - i));
      idle(1'b1);
    end
    check("drain_done", bus.dec_valid, 1'b0);

    // Decode and masking.
    step(1'b1, 32'h300, 32'h40B50533, 1'b0, 1'b0);
    check("sub_op", bus.op_code, OpSub);
    check("sub_rs2", bus.rs2, 5'd11);
    check("sub_imm", bus.imm, 32'd0);
    idle(1'b1);
    step(1'b1, 32'h304, 32'hFE209EE3, 1'b0, 1'b0);
    check("bne_op", bus.op_code, OpBne);
    check("bne_rd", bus.rd, 5'd0);
    check("bne_imm", bus.imm, 32'hFFFFFFFC);
    idle(1'b1);

    // Illegal encodings still produce a valid NOP micro-op.
    step(1'b1, 32'h400, 32'h0000007F, 1'b0, 1'b0);
    check("ill7f_illegal", bus.illegal, 1'b1);
    check("ill7f_op", bus.op_code, OpNop);
    check("ill7f_valid", bus.dec_valid, 1'b1);
    idle(1'b1);
    step(1'b1, 32'h404, 32'h40009093, 1'b0, 1'b0);
    check("illslli_illegal", bus.illegal, 1'b1);
    check("illslli_op", bus.op_code, OpNop);
    check("illslli_class", bus.op_class, ClassNop);
    idle(1'b1);

    // Flush with two queued words, a held micro-op and a fetch in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 32'h00100113, 1'b0, 1'b0);
    check("preflush_count", count, 3'd2);
    check("preflush_valid", bus.dec_valid, 1'b1);
    step(1'b1, 32'h900, 32'h00700193, 1'b1, 1'b1);
    check("flush_count", count, 3'd0);
    check("flush_valid", bus.dec_valid, 1'b0);
    idle(1'b1);
    check("flush_word_absent", bus.dec_valid, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 99) < 60, $urandom, rand_inst(),
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 2);
    for (int i = 0; i < Depth + 3; i++) idle(1'b1);
    check("end_dec_valid", bus.dec_valid, 1'b0);
    check("end_count", count, 3'd0);
    check("end_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
